// File: rtl/perf_snapshot_unit.sv
// Captures a timestamp plus the generic performance counters on a threshold-interrupt edge
// and streams them to memory. Optional ring of snapshot slots behind PERF_SNAP_WRAP_EN.
module perf_snapshot_unit #(
  parameter int unsigned NUM_COUNTERS = 6,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned SNAP_SLOTS   = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        enable_i,
  input  logic        irq_i,
  input  logic        clear_i,
  input  logic [63:0] cycle_count_i,
  input  logic [63:0] base_addr_i,
  output logic [11:0] cnt_addr_o,
  input  logic [63:0] cnt_data_i,
  output logic        wr_req_o,
  input  logic        wr_gnt_i,
  output logic [63:0] wr_addr_o,
  output logic [63:0] wr_data_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        overrun_o
);

  localparam int unsigned IdxW  = (NUM_COUNTERS > 1) ? $clog2(NUM_COUNTERS) : 1;
  localparam int unsigned WordW = $clog2(NUM_COUNTERS + 1);
  localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW  = PtrW + 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_COUNTERS - 1);

  typedef enum logic [2:0] {StIdle, StHdr, StRead, StDrain, StDone} state_e;

  state_e            state_q, state_d;
  logic              irq_q, trig;
  logic [63:0]       ts_q, ts_d, base_q, base_d, slot_addr;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [WordW-1:0]  wcnt_q, wcnt_d;
  logic [63:0]       mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]   wptr_q, rptr_q;
  logic [CntW-1:0]   count_q;
  logic              full, push, pop;
  logic [63:0]       push_data;

  assign trig = irq_i & ~irq_q & enable_i;
  // Push is gated on the registered count, so a full FIFO blocks even when popping.
  assign full = (count_q == CntW'(FIFO_DEPTH));
  assign pop  = wr_req_o & wr_gnt_i;

`ifdef PERF_SNAP_WRAP_EN
  localparam int unsigned SlotW = (SNAP_SLOTS > 1) ? $clog2(SNAP_SLOTS) : 1;
  logic [SlotW-1:0] slot_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      slot_q <= '0;
    end else if (state_q == StDone) begin
      slot_q <= (slot_q == SlotW'(SNAP_SLOTS - 1)) ? '0 : slot_q + 1'b1;
    end
  end

  assign slot_addr = base_addr_i + 64'(slot_q) * 64'((NUM_COUNTERS + 1) * 8);
`else
  logic unused_snap_slots;
  assign unused_snap_slots = ^32'(SNAP_SLOTS);
  assign slot_addr = base_addr_i;
`endif

  always_comb begin
    state_d    = state_q;
    ts_d       = ts_q;
    base_d     = base_q;
    idx_d      = idx_q;
    push       = 1'b0;
    push_data  = ts_q;
    cnt_addr_o = '0;
    done_o     = 1'b0;
    wcnt_d     = pop ? wcnt_q + 1'b1 : wcnt_q;
    unique case (state_q)
      StIdle: begin
        if (trig) begin
          ts_d    = cycle_count_i;
          base_d  = slot_addr;
          idx_d   = '0;
          wcnt_d  = '0;
          state_d = StHdr;
        end
      end
      StHdr: begin
        if (!full) begin
          push    = 1'b1;
          state_d = StRead;
        end
      end
      StRead: begin
        cnt_addr_o = 12'hB03 + 12'(idx_q);
        if (!full) begin
          push      = 1'b1;
          push_data = cnt_data_i;
          if (idx_q == LastIdx) state_d = StDrain;
          else                  idx_d   = idx_q + 1'b1;
        end
      end
      StDrain: begin
        if (count_q == '0) state_d = StDone;
      end
      StDone: begin
        done_o  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      irq_q     <= 1'b0;
      ts_q      <= '0;
      base_q    <= '0;
      idx_q     <= '0;
      wcnt_q    <= '0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
      overrun_o <= 1'b0;
    end else begin
      state_q <= state_d;
      irq_q   <= irq_i;
      ts_q    <= ts_d;
      base_q  <= base_d;
      idx_q   <= idx_d;
      wcnt_q  <= wcnt_d;
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      count_q <= count_q + CntW'(push) - CntW'(pop);
      // Losing a trigger takes priority over a simultaneous clear.
      if (trig && state_q != StIdle) overrun_o <= 1'b1;
      else if (clear_i)              overrun_o <= 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wptr_q] <= push_data;
  end

  assign busy_o    = (state_q != StIdle);
  assign wr_req_o  = (count_q != '0);
  assign wr_data_o = wr_req_o ? mem_q[rptr_q] : '0;
  assign wr_addr_o = wr_req_o ? base_q + (64'(wcnt_q) << 3) : '0;

endmodule

// File: tb/tb_perf_snapshot_unit.sv
// Bench for perf_snapshot_unit: directed vector table, hand-written corner sequences and
// randomized snapshots checked against a transaction-level write model.
module tb_perf_snapshot_unit;

  localparam int NC    = 6;
  localparam int SLOTS = 4;

  logic        clk = 1'b0;
  logic        rst_i, enable_i, irq_i, clear_i, wr_gnt_i;
  logic [63:0] cycle_count_i, base_addr_i, cnt_data_i;
  logic [11:0] cnt_addr_o;
  logic        wr_req_o, busy_o, done_o, overrun_o;
  logic [63:0] wr_addr_o, wr_data_o;

  perf_snapshot_unit dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .enable_i     (enable_i),
    .irq_i        (irq_i),
    .clear_i      (clear_i),
    .cycle_count_i(cycle_count_i),
    .base_addr_i  (base_addr_i),
    .cnt_addr_o   (cnt_addr_o),
    .cnt_data_i   (cnt_data_i),
    .wr_req_o     (wr_req_o),
    .wr_gnt_i     (wr_gnt_i),
    .wr_addr_o    (wr_addr_o),
    .wr_data_o    (wr_data_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .overrun_o    (overrun_o)
  );

  always #5 clk = ~clk;

  logic [63:0] cyc = '0;
  logic [63:0] cyc_off = '0;
  always @(posedge clk) cyc <= cyc + 64'd1;
  assign cycle_count_i = cyc + cyc_off;

  logic [63:0] cval [NC];
  always_comb begin
    cnt_data_i = 64'hDEAD_BEEF_0BAD_F00D;
    for (int k = 0; k < NC; k++) if (cnt_addr_o == 12'(12'hB03 + k)) cnt_data_i = cval[k];
  end

  int checks = 0;
  int failures = 0;

  typedef struct packed {logic [63:0] addr; logic [63:0] data;} wr_t;
  wr_t exp_q[$];
  int  model_slot = 0;
  bit  model_ovr = 0;
  bit  gnt_rand = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Every granted write must be the next one the model expects.
  always @(negedge clk) begin
    if (!rst_i && wr_req_o && wr_gnt_i) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_write actual=%h:%h expected=none", wr_addr_o, wr_data_o);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if (e.addr !== wr_addr_o || e.data !== wr_data_o) begin
          failures++;
          $display("FAIL write actual=%h:%h expected=%h:%h", wr_addr_o, wr_data_o, e.addr, e.data);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (gnt_rand) wr_gnt_i = 1'($urandom_range(0, 1));
  endtask

  // Snapshot as seen from memory: timestamp then each counter, consecutive words at the slot.
  task automatic model_expect();
    logic [63:0] sb;
    wr_t e;
    sb = base_addr_i;
`ifdef PERF_SNAP_WRAP_EN
    sb = base_addr_i + 64'(model_slot) * 64'((NC + 1) * 8);
    model_slot = (model_slot + 1) % SLOTS;
`endif
    e.addr = sb;
    e.data = cycle_count_i;
    exp_q.push_back(e);
    for (int k = 0; k < NC; k++) begin
      e.addr = sb + 64'(8 * (k + 1));
      e.data = cval[k];
      exp_q.push_back(e);
    end
  endtask

  task automatic start_snap();
    if (enable_i) model_expect();
    irq_i = 1'b1;
    tick();
    irq_i = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy_o && n < budget) begin
      tick();
      n++;
    end
    check("wait_idle_busy", 64'(busy_o), 64'd0);
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    tick();
    tick();
    rst_i = 1'b0;
    exp_q.delete();
    model_slot = 0;
    model_ovr = 0;
  endtask

  typedef struct {
    logic irq; logic [11:0] cnt; logic busy; logic req; logic done;
    logic [63:0] waddr; logic [63:0] wdata;
  } vec_t;
  vec_t vecs[11];

  function automatic vec_t mk(logic irq, logic [11:0] cnt, logic busy, logic req, logic done,
                              logic [63:0] waddr, logic [63:0] wdata);
    vec_t v;
    v.irq = irq; v.cnt = cnt; v.busy = busy; v.req = req; v.done = done;
    v.waddr = waddr; v.wdata = wdata;
    return v;
  endfunction

  initial begin
    rst_i = 1'b1; enable_i = 1'b1; irq_i = 1'b0; clear_i = 1'b0; wr_gnt_i = 1'b1;
    base_addr_i = 64'h8000_0000;
    for (int k = 0; k < NC; k++) cval[k] = 64'(k + 1);

    vecs[0]  = mk(1, 12'h000, 1, 0, 0, 64'h0, 64'h0);
    vecs[1]  = mk(0, 12'hB03, 1, 1, 0, 64'h8000_0000, 64'd100);
    vecs[2]  = mk(0, 12'hB04, 1, 1, 0, 64'h8000_0008, 64'd1);
    vecs[3]  = mk(0, 12'hB05, 1, 1, 0, 64'h8000_0010, 64'd2);
    vecs[4]  = mk(0, 12'hB06, 1, 1, 0, 64'h8000_0018, 64'd3);
    vecs[5]  = mk(0, 12'hB07, 1, 1, 0, 64'h8000_0020, 64'd4);
    vecs[6]  = mk(0, 12'hB08, 1, 1, 0, 64'h8000_0028, 64'd5);
    vecs[7]  = mk(0, 12'h000, 1, 1, 0, 64'h8000_0030, 64'd6);
    vecs[8]  = mk(0, 12'h000, 1, 0, 0, 64'h0, 64'h0);
    vecs[9]  = mk(0, 12'h000, 1, 0, 1, 64'h0, 64'h0);
    vecs[10] = mk(0, 12'h000, 0, 0, 0, 64'h0, 64'h0);

    do_reset();
    check("rst_busy", 64'(busy_o), 0);
    check("rst_req", 64'(wr_req_o), 0);
    check("rst_cnt_addr", 64'(cnt_addr_o), 0);
    check("rst_done", 64'(done_o), 0);
    check("rst_overrun", 64'(overrun_o), 0);
    check("rst_wr_addr", wr_addr_o, 0);
    check("rst_wr_data", wr_data_o, 0);

    // Basic snapshot, timestamp 100.
    for (int n = 0; n < 200 && cycle_count_i < 64'd100; n++) tick();
    check("basic_ts_align", cycle_count_i, 64'd100);
    model_expect();
    for (int i = 0; i < 11; i++) begin
      irq_i = vecs[i].irq;
      tick();
      check($sformatf("vec%0d_busy", i), 64'(busy_o), 64'(vecs[i].busy));
      check($sformatf("vec%0d_req", i), 64'(wr_req_o), 64'(vecs[i].req));
      check($sformatf("vec%0d_cnt_addr", i), 64'(cnt_addr_o), 64'(vecs[i].cnt));
      check($sformatf("vec%0d_done", i), 64'(done_o), 64'(vecs[i].done));
      if (vecs[i].req) begin
        check($sformatf("vec%0d_wr_addr", i), wr_addr_o, vecs[i].waddr);
        check($sformatf("vec%0d_wr_data", i), wr_data_o, vecs[i].wdata);
      end
    end
    check("basic_all_written", 64'(exp_q.size()), 0);

    // Backpressure: grant held low, FIFO fills, head must stay stable.
    for (int k = 0; k < NC; k++) cval[k] = {$urandom, $urandom};
    wr_gnt_i = 1'b0;
    start_snap();
    for (int i = 0; i < 20; i++) begin
      tick();
      if (wr_req_o) begin
        check("bp_stable_addr", wr_addr_o, exp_q[0].addr);
        check("bp_stable_data", wr_data_o, exp_q[0].data);
      end
    end
    check("bp_cnt_addr_hold", 64'(cnt_addr_o), 64'h0B06);
    check("bp_req_held", 64'(wr_req_o), 1);
    wr_gnt_i = 1'b1;
    wait_idle(50);
    check("bp_all_written", 64'(exp_q.size()), 0);

    // Overrun: second edge while busy.
    start_snap();
    tick();
    tick();
    irq_i = 1'b1;
    tick();
    irq_i = 1'b0;
    check("ovr_set", 64'(overrun_o), 1);
    wait_idle(50);
    repeat (5) tick();
    check("ovr_sticky", 64'(overrun_o), 1);
    check("ovr_only_7", 64'(exp_q.size()), 0);
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    model_slot = 0;
    check("ovr_clear", 64'(overrun_o), 0);

    // Level irq gives one snapshot.
    model_expect();
    irq_i = 1'b1;
    repeat (50) tick();
    irq_i = 1'b0;
    wait_idle(50);
    repeat (3) tick();
    check("level_one_snap", 64'(exp_q.size()), 0);
    check("level_no_ovr", 64'(overrun_o), 0);

    // Disabled: edge is ignored.
    enable_i = 1'b0;
    start_snap();
    repeat (15) tick();
    check("dis_busy", 64'(busy_o), 0);
    check("dis_ovr", 64'(overrun_o), 0);
    enable_i = 1'b1;

    // Reset mid-READ at idx 2, then a clean snapshot.
    start_snap();
    tick();
    tick();
    tick();
    check("mid_rst_idx2", 64'(cnt_addr_o), 64'h0B05);
    do_reset();
    check("mid_rst_busy", 64'(busy_o), 0);
    check("mid_rst_req", 64'(wr_req_o), 0);
    check("mid_rst_cnt_addr", 64'(cnt_addr_o), 0);
    start_snap();
    wait_idle(50);
    check("post_rst_snap", 64'(exp_q.size()), 0);

`ifdef PERF_SNAP_WRAP_EN
    begin
      logic [63:0] starts [5];
      starts[0] = 64'h1000; starts[1] = 64'h1038; starts[2] = 64'h1070;
      starts[3] = 64'h10A8; starts[4] = 64'h1000;
      do_reset();
      base_addr_i = 64'h1000;
      for (int i = 0; i < 5; i++) begin
        start_snap();
        for (int n = 0; n < 10 && !wr_req_o; n++) tick();
        check($sformatf("wrap_start%0d", i), wr_addr_o, starts[i]);
        wait_idle(50);
      end
      check("wrap_all_written", 64'(exp_q.size()), 0);
    end
`endif

    // Randomized snapshots with random grant, enable drops and extra edges.
    cyc_off = {$urandom, $urandom};
    gnt_rand = 1;
    for (int it = 0; it < 25; it++) begin
      base_addr_i = {$urandom, $urandom};
      for (int k = 0; k < NC; k++) cval[k] = {$urandom, $urandom};
      enable_i = ($urandom_range(0, 3) != 0);
      start_snap();
      if (enable_i) begin
        repeat ($urandom_range(1, 8)) tick();
        if ($urandom_range(0, 1) == 1 && exp_q.size() > 0) begin
          if ($urandom_range(0, 1) == 1) enable_i = 1'b0;
          if (enable_i) model_ovr = 1;
          irq_i = 1'b1;
          tick();
          irq_i = 1'b0;
        end
      end
      wait_idle(300);
      tick();
      tick();
      check($sformatf("rand%0d_drained", it), 64'(exp_q.size()), 0);
      check($sformatf("rand%0d_ovr", it), 64'(overrun_o), 64'(model_ovr));
      if ($urandom_range(0, 2) == 0) begin
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        model_ovr = 0;
        model_slot = 0;
        check($sformatf("rand%0d_clear", it), 64'(overrun_o), 0);
      end
      enable_i = 1'b1;
    end
    gnt_rand = 0;
    wr_gnt_i = 1'b1;
    repeat (5) tick();
    check("final_drained", 64'(exp_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
